// File: rtl/seg_pkg.sv
// Shared definitions for the scanned 7-segment receive path: segment patterns,
// receiver FSM states and the pattern-to-hex decode function.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2,
    HOLD   = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } seg_decode_t;

  // Active-high abcdefg in; the all-off pattern is legal and flagged blank.
  function automatic seg_decode_t seg_decode(input logic [6:0] seg);
    seg_decode_t d;
    d.legal = 1'b1;
    d.blank = 1'b0;
    d.value = 4'h0;
    case (seg)
      SEG_0:     d.value = 4'h0;
      SEG_1:     d.value = 4'h1;
      SEG_2:     d.value = 4'h2;
      SEG_3:     d.value = 4'h3;
      SEG_4:     d.value = 4'h4;
      SEG_5:     d.value = 4'h5;
      SEG_6:     d.value = 4'h6;
      SEG_7:     d.value = 4'h7;
      SEG_8:     d.value = 4'h8;
      SEG_9:     d.value = 4'h9;
      SEG_A:     d.value = 4'hA;
      SEG_B:     d.value = 4'hB;
      SEG_C:     d.value = 4'hC;
      SEG_D:     d.value = 4'hD;
      SEG_E:     d.value = 4'hE;
      SEG_F:     d.value = 4'hF;
      SEG_BLANK: d.blank = 1'b1;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern decoder: abcdefg -> {legal, blank, value}.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_legal,
  output logic       o_blank,
  output logic [3:0] o_value
);

  seg_decode_t w_dec;

  assign w_dec   = seg_decode(i_seg);
  assign o_legal = w_dec.legal;
  assign o_blank = w_dec.blank;
  assign o_value = w_dec.value;

endmodule

// File: rtl/seg_scan_receiver.sv
// Receiver for a 4-digit multiplexed 7-segment scan: waits for each digit slot
// to settle, decodes it, assembles frames and flags bad patterns / lost scan.
module seg_scan_receiver
  import seg_pkg::*;
#(
  parameter bit          EN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] enable_in,
  input  logic [6:0] segment_in,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] blank,
  output logic       frame_strobe,
  output logic       bad_pattern,
  output logic       scan_lost
);

  localparam logic [7:0]  STABLE_MAX = STABLE_CYCLES[7:0];
  localparam logic [19:0] TO_MAX     = TIMEOUT_CYCLES[19:0];

  logic [3:0]       r_en_s1, r_en_s2;
  logic [6:0]       r_seg_s1, r_seg_s2;
  logic [10:0]      r_prev, r_acc;
  logic [7:0]       r_cnt;
  logic [19:0]      r_to_cnt;
  scan_state_t      r_state, w_next_state;
  logic             w_capture;
  logic [3:0][3:0]  r_digit;
  logic [3:0]       r_blank, r_seen;
  logic             r_frame_strobe, r_bad_pattern;

  logic [3:0]  w_en;
  logic [6:0]  w_seg;
  logic [10:0] w_sample;
  logic        w_onehot, w_changed;
  logic        w_dec_legal, w_dec_blank;
  logic [3:0]  w_dec_value;
  logic [3:0]  w_slot;

  assign w_en      = r_en_s2 ^ {4{EN_ACTIVE_LOW}};
  assign w_seg     = r_seg_s2 ^ {7{SEG_ACTIVE_LOW}};
  assign w_sample  = {w_en, w_seg};
  assign w_onehot  = $onehot(w_en);
  assign w_changed = (w_sample != r_prev);
  assign w_slot    = r_acc[10:7];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en_s1  <= '0;
      r_en_s2  <= '0;
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_prev   <= '0;
      r_cnt    <= '0;
      r_state  <= HUNT;
      r_acc    <= '0;
    end else begin
      r_en_s1  <= enable_in;
      r_en_s2  <= r_en_s1;
      r_seg_s1 <= segment_in;
      r_seg_s2 <= r_seg_s1;
      r_prev   <= w_sample;
      r_state  <= w_next_state;
      if (w_capture) r_acc <= r_prev;
      // r_cnt is the length of the current run of identical samples.
      if (r_state == HUNT && !w_onehot) r_cnt <= '0;
      else if (w_changed)               r_cnt <= 8'd1;
      else if (r_cnt != 8'hFF)          r_cnt <= r_cnt + 8'd1;
    end
  end

  // NOTE: defaults first so no path through the case can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      HUNT:   if (w_onehot) w_next_state = SETTLE;
      SETTLE: begin
        // Run has reached its count: r_prev still holds the settled sample.
        if (r_cnt >= STABLE_MAX) begin
          w_next_state = ACCEPT;
          w_capture    = 1'b1;
        end else if (w_changed && !w_onehot) begin
          w_next_state = HUNT;
        end
      end
      ACCEPT: w_next_state = HOLD;
      HOLD:   if (w_sample != r_acc) w_next_state = HUNT;
      default: w_next_state = HUNT;
    endcase
  end

  seg_pattern_decode u_decode (
    .i_seg   (r_acc[6:0]),
    .o_legal (w_dec_legal),
    .o_blank (w_dec_blank),
    .o_value (w_dec_value)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_digit        <= '0;
      r_blank        <= 4'b1111;
      r_seen         <= '0;
      r_frame_strobe <= 1'b0;
      r_bad_pattern  <= 1'b0;
      r_to_cnt       <= '0;
    end else begin
      r_frame_strobe <= 1'b0;
      r_bad_pattern  <= 1'b0;
      if (r_state == ACCEPT) r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 20'd1;
      if (r_state == ACCEPT) begin
        if (!w_dec_legal) begin
          r_bad_pattern <= 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (w_slot[i]) begin
              if (!w_dec_blank) r_digit[i] <= w_dec_value;
              r_blank[i] <= w_dec_blank;
            end
          end
          if ((r_seen | w_slot) == 4'b1111) begin
            r_seen         <= '0;
            r_frame_strobe <= 1'b1;
          end else begin
            r_seen <= r_seen | w_slot;
          end
        end
      end
    end
  end

  assign digit3       = r_digit[3];
  assign digit2       = r_digit[2];
  assign digit1       = r_digit[1];
  assign digit0       = r_digit[0];
  assign blank        = r_blank;
  assign frame_strobe = r_frame_strobe;
  assign bad_pattern  = r_bad_pattern;
  assign scan_lost    = (r_to_cnt == TO_MAX);

endmodule

// File: tb/tb_seg_scan_receiver.sv
// Self-checking bench for seg_scan_receiver: run-length reference model with a
// per-cycle compare, directed scenarios with literal expectations, random scan.
module tb_seg_scan_receiver;

  localparam int S = 8;
  localparam int T = 100;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] enable_in;
  logic [6:0] segment_in;
  logic [3:0] digit3, digit2, digit1, digit0, blank;
  logic       frame_strobe, bad_pattern, scan_lost;

  always #5 clk = ~clk;

  seg_scan_receiver #(
    .EN_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW(1'b0),
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_in   (enable_in),
    .segment_in  (segment_in),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .blank       (blank),
    .frame_strobe(frame_strobe),
    .bad_pattern (bad_pattern),
    .scan_lost   (scan_lost)
  );

  int n_checks = 0;
  int n_errors = 0;
  int obs_fs   = 0;
  int obs_bad  = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Value 0..15, 16 for all-off, -1 for an illegal pattern.
  function automatic int lut(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (SEG_TAB[i] == s) return i;
    if (s == 7'h00) return 16;
    return -1;
  endfunction

  function automatic logic [6:0] pick_illegal();
    logic [6:0] s;
    do s = 7'($urandom); while (lut(s) != -1);
    return s;
  endfunction

  // Reference model: a run of identical inputs with one-hot enable is accepted
  // when it reaches S samples; its effect is visible 4 clocks later.
  typedef struct {
    int         due;
    logic [3:0] en;
    logic [6:0] seg;
  } ev_t;

  ev_t        m_q[$];
  logic [3:0] m_digit [4];
  logic [3:0] m_blank, m_seen;
  logic       m_fs, m_bad;
  int         m_lost;
  logic [10:0] m_run_val;
  int         m_run_len;
  int         cyc = 0;

  initial begin
    ev_t        ev;
    logic [10:0] cur;
    int         val, slot;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_blank   = 4'hF;
        m_seen    = 4'h0;
        m_fs      = 1'b0;
        m_bad     = 1'b0;
        m_lost    = 0;
        m_run_len = 0;
        m_run_val = '0;
        m_q.delete();
      end else begin
        m_fs  = 1'b0;
        m_bad = 1'b0;
        if (m_lost < T) m_lost++;
        while (m_q.size() > 0 && m_q[0].due <= cyc) begin
          ev     = m_q.pop_front();
          m_lost = 0;
          val    = lut(ev.seg);
          slot   = 0;
          for (int k = 0; k < 4; k++) if (ev.en[k]) slot = k;
          if (val < 0) begin
            m_bad = 1'b1;
          end else begin
            if (val == 16) m_blank[slot] = 1'b1;
            else begin
              m_digit[slot] = val[3:0];
              m_blank[slot] = 1'b0;
            end
            m_seen[slot] = 1'b1;
            if (m_seen == 4'hF) begin
              m_fs   = 1'b1;
              m_seen = 4'h0;
            end
          end
        end
        cur = {~enable_in, segment_in};
        if (m_run_len > 0 && cur == m_run_val) begin
          if (m_run_len < 1000) m_run_len++;
        end else begin
          m_run_val = cur;
          m_run_len = 1;
        end
        if (m_run_len == S && $onehot(cur[10:7])) begin
          ev.due = cyc + 4;
          ev.en  = cur[10:7];
          ev.seg = cur[6:0];
          m_q.push_back(ev);
        end
      end
    end
  end

  initial begin
    logic [31:0] dut_vec, exp_vec;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        if (frame_strobe === 1'b1) obs_fs++;
        if (bad_pattern === 1'b1) obs_bad++;
        dut_vec = {9'd0, digit3, digit2, digit1, digit0, blank,
                   frame_strobe, bad_pattern, scan_lost};
        exp_vec = {9'd0, m_digit[3], m_digit[2], m_digit[1], m_digit[0], m_blank,
                   m_fs, m_bad, (m_lost == T)};
        check("cycle outputs", dut_vec, exp_vec);
      end
    end
  end

  task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable_in  = ~en;
      segment_in = seg;
    end
  endtask

  task automatic idle(input int n);
    drive(4'b0000, 7'h00, n);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    enable_in  = 4'hF;
    segment_in = 7'h00;
    repeat (4) @(negedge clk);
    cmp_en = 1'b1;
    check("reset state", {9'd0, digit3, digit2, digit1, digit0, blank,
                          frame_strobe, bad_pattern, scan_lost}, {9'd0, 16'h0000, 4'hF, 3'b000});
    @(negedge clk);
    reset = 1'b1;
    idle(5);

    // Clean scan of all four slots
    obs_fs = 0; obs_bad = 0;
    drive(4'b1000, 7'h79, 20);
    drive(4'b0100, 7'h30, 20);
    drive(4'b0010, 7'h6D, 20);
    drive(4'b0001, 7'h7E, 20);
    idle(10);
    check("clean digit3", 32'(digit3), 32'd3);
    check("clean digit2", 32'(digit2), 32'd1);
    check("clean digit1", 32'(digit1), 32'd2);
    check("clean digit0", 32'(digit0), 32'd0);
    check("clean blank", 32'(blank), 32'h0);
    check("clean strobes", 32'(obs_fs), 32'd1);
    check("clean bad", 32'(obs_bad), 32'd0);

    // Glitching slot 2 settles to 8
    for (int i = 0; i < 10; i++) drive(4'b0100, (i % 2 == 0) ? 7'h6D : 7'h7F, 3);
    check("glitch no accept", 32'(digit2), 32'd1);
    drive(4'b0100, 7'h7F, 20);
    idle(10);
    check("glitch digit2", 32'(digit2), 32'd8);

    // Illegal then blank on slot 1
    obs_fs = 0; obs_bad = 0;
    drive(4'b0010, 7'h01, 20);
    idle(10);
    check("illegal bad count", 32'(obs_bad), 32'd1);
    check("illegal digit1", 32'(digit1), 32'd2);
    drive(4'b0001, 7'h7E, 20);
    drive(4'b0010, 7'h00, 20);
    idle(10);
    check("blank mask", 32'(blank), 32'b0010);
    check("blank digit1 kept", 32'(digit1), 32'd2);
    check("blank no strobe", 32'(obs_fs), 32'd0);

    // Multi-hot and zero enable
    obs_fs = 0; obs_bad = 0;
    drive(4'b0011, 7'h79, 50);
    drive(4'b0000, 7'h79, 50);
    check("multihot digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h3820);
    check("multihot blank", 32'(blank), 32'b0010);
    check("multihot events", 32'(obs_fs + obs_bad), 32'd0);

    // Timeout and recovery; slot 3 completes the frame started above
    obs_fs = 0;
    check("timeout expired", 32'(scan_lost), 32'd1);
    drive(4'b1000, 7'h79, 20);
    check("timeout cleared", 32'(scan_lost), 32'd0);
    check("out-of-order frame", 32'(obs_fs), 32'd1);
    idle(60);
    check("timeout not yet", 32'(scan_lost), 32'd0);
    idle(40);
    check("timeout again", 32'(scan_lost), 32'd1);

    // Reset mid-frame discards the partial frame
    pulse_reset();
    obs_fs = 0;
    drive(4'b1000, 7'h5B, 20);
    drive(4'b0100, 7'h5F, 20);
    idle(10);
    check("pre-reset digit3", 32'(digit3), 32'd5);
    pulse_reset();
    drive(4'b0010, 7'h70, 20);
    drive(4'b0001, 7'h7B, 20);
    idle(10);
    check("reset frame digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0079);
    check("reset frame blank", 32'(blank), 32'b1100);
    check("reset frame strobe", 32'(obs_fs), 32'd0);

    // Randomized scan with glitches, illegal patterns and gaps
    for (int d = 0; d < 150; d++) begin
      logic [3:0] en, gap_en;
      logic [6:0] seg, gs, prev_g;
      int r;
      en = 4'b0001 << $urandom_range(3, 0);
      r  = $urandom_range(99, 0);
      if (r < 80)      seg = SEG_TAB[$urandom_range(15, 0)];
      else if (r < 90) seg = 7'h00;
      else             seg = pick_illegal();
      if ($urandom_range(99, 0) < 30) begin
        prev_g = 7'h00;
        for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
          do gs = 7'($urandom); while (gs == prev_g);
          drive(en, gs, $urandom_range(6, 1));
          prev_g = gs;
        end
      end
      drive(en, seg, $urandom_range(S + 20, S + 6));
      if ($urandom_range(9, 0) < 2) begin
        do gap_en = 4'($urandom); while ($onehot(gap_en));
        drive(gap_en, 7'($urandom), $urandom_range(10, 1));
      end
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_receiver.md
Name: seg_scan_receiver

Overview:
Receive-side counterpart of the 4-digit multiplexed 7-segment display driver. It samples the digit-enable and abcdefg segment lines of a scanned display, waits for each digit slot to settle, and decodes each slot back to a 4-bit hex value. It assembles complete 4-digit frames for a self-checking display monitor, which can be used in the bench or on a second board. It also flags illegal segment patterns and a stalled scan.

Parameters:
EN_ACTIVE_LOW, 1, enable_in lines are active-low when 1; active-high when 0
SEG_ACTIVE_LOW, 0, segment_in lines are active-low when 1; active-high when 0
STABLE_CYCLES, 8, consecutive identical samples required before a digit slot is accepted (range 2..255)
TIMEOUT_CYCLES, 65535, clocks with no accepted digit before scan_lost asserts (range 16..2^20-1)

Ports:
clk  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
enable_in  input  4  digit select from the scanning driver; bit3 = leftmost digit
segment_in  input  7  segment lines; bit6 = a … bit0 = g
digit3  output  4  last accepted value of digit slot 3
digit2  output  4  last accepted value of digit slot 2
digit1  output  4  last accepted value of digit slot 1
digit0  output  4  last accepted value of digit slot 0
blank  output  4  per slot: 1 = last accepted pattern was all-off
frame_strobe  output  1  one-clock pulse when all four slots have been accepted since the previous strobe
bad_pattern  output  1  one-clock pulse when a settled pattern matches no table entry
scan_lost  output  1  level; high while the timeout is expired

Behaviour:
- Reset (reset = 0 at a clk edge):
  - digit0..digit3 = 0; blank = 4'b1111.
  - frame_strobe = 0; bad_pattern = 0; scan_lost = 0.
  - Synchronizers, stability counter, slot-seen mask and timeout counter cleared; FSM goes to HUNT.
  - Reset asserted mid-operation discards any partial frame.
- Input path:
  - enable_in and segment_in each pass through a 2-flop synchronizer.
  - Polarity is then normalised to active-high per EN_ACTIVE_LOW and SEG_ACTIVE_LOW.
- The sample is the concatenation {en, seg}, 11 bits. The stability counter resets to 1 whenever the sample differs from the previous clock's sample, and saturates otherwise.
- FSM states:
  - HUNT: waits for en to be one-hot.
    - Zero or multi-hot en keeps the FSM in HUNT and holds the counter at 0.
    - When en is one-hot, go to SETTLE.
  - SETTLE:
    - If the sample changes, restart the count, or return to HUNT if en is no longer one-hot.
    - When the counter reaches STABLE_CYCLES, go to ACCEPT.
  - ACCEPT (one cycle): decode seg.
    - Legal hex: write the selected digitN, clear blank[N], set seen[N].
    - All-off: set blank[N], leave digitN unchanged, set seen[N].
    - Illegal: pulse bad_pattern; no digit, blank or seen update.
    - Then go to HOLD.
  - HOLD: stays until the sample changes, then go to HUNT.
    - Each slot is therefore accepted once per dwell.
- Decode table (active-high abcdefg → value):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9
  - 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F
  - 00→blank; every other pattern is illegal.
- Frame completion:
  - frame_strobe pulses in the cycle after the ACCEPT that makes seen = 4'b1111; seen clears in that same cycle.
  - The slot order within a frame is irrelevant.
  - Re-accepting an already-seen slot before completion updates its digit and does not strobe.
- Latency: input change to digitN update = 2 (sync) + STABLE_CYCLES + 1 clocks.
- Timeout:
  - The counter increments every clock and clears on each ACCEPT, whether legal, blank or illegal.
  - scan_lost = 1 when the counter reaches TIMEOUT_CYCLES. The counter saturates there.
  - scan_lost deasserts on the next ACCEPT.
- Simultaneous events: reset has priority over everything. An ACCEPT in the same cycle that the timeout expires clears the timeout, so scan_lost stays 0.

Decomposition:
- Shared package seg_pkg holds:
  - the 16 segment pattern constants SEG_0..SEG_F and SEG_BLANK;
  - the FSM state enum (HUNT, SETTLE, ACCEPT, HOLD);
  - the segment-to-hex decode function returning {legal, blank, value[3:0]}.
- One natural sub-module: seg_pattern_decode, combinational, from the 7-bit seg input to {legal, blank, value}. It is reusable by the existing display path's checkers.

Test Plan:
1. Clean scan, defaults: drive slots 3..0 with 79, 30, 6D, 7E, 20 clocks each → digit3..0 = 3, 1, 2, 0; exactly one frame_strobe after slot 0; bad_pattern never asserts.
2. Glitch rejection: in slot 2, toggle the segments 6D↔7F every 3 clocks for 30 clocks, then hold 7F for 20 clocks → no ACCEPT during toggling; digit2 = 8 after settling.
3. Illegal/blank: slot 1 drives 01, then after re-scan drives 00 → one bad_pattern pulse and digit1 unchanged; then blank[1] = 1 and seen[1] set.
4. Multi-hot/zero enable: enable = 0011, then 0000, for 50 clocks each → FSM stays in HUNT; no outputs change.
5. Timeout: stop scanning with TIMEOUT_CYCLES = 100 → scan_lost rises 100 clocks after the last ACCEPT; resuming the scan drops scan_lost at the next ACCEPT.
6. Reset mid-frame: accept slots 3 and 2, pulse reset low for 1 clock, accept slots 1 and 0 → no frame_strobe; digit3 and digit2 = 0 and blank[3:2] = 11.
